// File: rtl/binary_to_bcd_seq_if.sv
// binary_to_bcd_seq_if: request/result bundle between a converter client and the converter
interface binary_to_bcd_seq_if #(
   parameter int binWidth  = 8,
   parameter int numDigits = 3
);
   logic                   ena;
   logic                   start;
   logic [binWidth-1:0]    binIn;
   logic                   busy;
   logic                   done;
   logic [4*numDigits-1:0] bcdOut;
   modport master (output ena, start, binIn, input busy, done, bcdOut);
   modport slave  (input ena, start, binIn, output busy, done, bcdOut);
endinterface

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: sequential double-dabble binary to packed BCD converter, one bit per enabled cycle
module binary_to_bcd_seq #(
   parameter int binWidth  = 8,
   parameter int numDigits = 3
) (
   input logic                clk,
   input logic                rst,
   binary_to_bcd_seq_if.slave bus
);
   localparam int AW = 4 * numDigits;
   localparam int CW = $clog2(binWidth + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [binWidth-1:0] sh_q, sh_d;
   logic [AW-1:0]       acc_q, acc_d, adj;
   logic [AW-1:0]       bcd_q, bcd_d;
   logic                busy_q, busy_d, done_q, done_d;
   // add 3 to every digit >= 5 so the following shift carries correctly into the next digit
   always_comb begin
      adj = acc_q;
      for (int i = 0; i < numDigits; i++)
         adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
   end
   // next state: ena gates every update; the top digit's carry falls off the shift, giving mod 10^numDigits
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      if (bus.ena && state_q == IDLE && bus.start) begin
         state_d = SHIFT;
         cnt_d   = CW'(binWidth);
         sh_d    = bus.binIn;
         acc_d   = '0;
      end else if (bus.ena && state_q == SHIFT) begin
         {acc_d, sh_d} = {adj[AW-2:0], sh_q, 1'b0};
         cnt_d         = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            bcd_d   = {adj[AW-2:0], sh_q[binWidth-1]};
            state_d = DONE;
         end
      end else if (bus.ena && state_q == DONE) begin
         state_d = IDLE;
      end
      busy_d = state_d != IDLE;
      done_d = state_d == DONE;
   end
   // state and registered outputs; reset overrides ena and clears everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         acc_q   <= '0;
         bcd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.bcdOut = bcd_q;
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq: directed and random checks of the BCD converter against an arithmetic model
module tb_binary_to_bcd_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   binary_to_bcd_seq_if #(.binWidth(8),  .numDigits(3)) bd ();
   binary_to_bcd_seq_if #(.binWidth(8),  .numDigits(2)) bn ();
   binary_to_bcd_seq_if #(.binWidth(16), .numDigits(5)) bw ();
   binary_to_bcd_seq #(.binWidth(8),  .numDigits(3)) u_d (.clk(clk), .rst(rst), .bus(bd.slave));
   binary_to_bcd_seq #(.binWidth(8),  .numDigits(2)) u_n (.clk(clk), .rst(rst), .bus(bn.slave));
   binary_to_bcd_seq #(.binWidth(16), .numDigits(5)) u_w (.clk(clk), .rst(rst), .bus(bw.slave));
   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] last_bcd = '0;
   // decimal digits of v, least significant first, truncated to nd digits
   function automatic logic [31:0] ref_bcd(input longint unsigned v, input int nd);
      logic [31:0] r;
      longint unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic conv_d(input logic [7:0] v);
      int c;
      bd.start = 1'b1;
      bd.binIn = v;
      tick;
      bd.start = 1'b0;
      bd.binIn = 8'($urandom);
      chk("busy_e0", 32'(bd.busy), 32'd1);
      chk("bcd_hold", 32'(bd.bcdOut), last_bcd);
      c = 0;
      while (!bd.done && c < 40) begin
         tick;
         c++;
      end
      chk("latency", c, 32'd8);
      chk("bcd", 32'(bd.bcdOut), ref_bcd(v, 3));
      tick;
      chk("done_pulse", 32'(bd.done), 32'd0);
      chk("idle_busy", 32'(bd.busy), 32'd0);
      last_bcd = ref_bcd(v, 3);
   endtask
   task automatic run_all(input logic [15:0] v);
      int c;
      bd.start = 1'b1;
      bn.start = 1'b1;
      bw.start = 1'b1;
      bd.binIn = v[7:0];
      bn.binIn = v[7:0];
      bw.binIn = v;
      tick;
      bd.start = 1'b0;
      bn.start = 1'b0;
      bw.start = 1'b0;
      c = 0;
      while (!bw.done && c < 40) begin
         tick;
         c++;
         if (c == 8) begin
            chk("d3_done", 32'(bd.done), 32'd1);
            chk("d3_bcd", 32'(bd.bcdOut), ref_bcd(64'(v[7:0]), 3));
            chk("d2_done", 32'(bn.done), 32'd1);
            chk("d2_bcd", 32'(bn.bcdOut), ref_bcd(64'(v[7:0]), 2));
         end
      end
      chk("w16_latency", c, 32'd16);
      chk("w16_bcd", 32'(bw.bcdOut), ref_bcd(64'(v), 5));
      tick;
      chk("w16_idle", 32'(bw.busy), 32'd0);
      last_bcd = ref_bcd(64'(v[7:0]), 3);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      int c;
      int seen;
      bd.ena = 1'b0; bd.start = 1'b0; bd.binIn = '0;
      bn.ena = 1'b1; bn.start = 1'b0; bn.binIn = '0;
      bw.ena = 1'b1; bw.start = 1'b0; bw.binIn = '0;
      rst = 1'b1;
      tick;
      tick;
      chk("rst_busy", 32'(bd.busy), 32'd0);
      chk("rst_done", 32'(bd.done), 32'd0);
      chk("rst_bcd", 32'(bd.bcdOut), 32'd0);
      rst = 1'b0;
      bd.ena = 1'b1;
      conv_d(8'd173);
      conv_d(8'd0);
      bd.start = 1'b1;
      bd.binIn = 8'd255;
      tick;
      c = 0;
      while (!bd.done && c < 40) begin
         tick;
         c++;
      end
      chk("held_latency", c, 32'd8);
      chk("held_bcd", 32'(bd.bcdOut), 32'h255);
      tick;
      chk("held_idle", 32'(bd.busy), 32'd0);
      tick;
      chk("held_reaccept", 32'(bd.busy), 32'd1);
      bd.start = 1'b0;
      c = 0;
      while (!bd.done && c < 40) begin
         tick;
         c++;
      end
      tick;
      bd.start = 1'b1;
      bd.binIn = 8'd99;
      tick;
      bd.start = 1'b0;
      tick;
      tick;
      bd.start = 1'b1;
      bd.binIn = 8'd7;
      tick;
      bd.start = 1'b0;
      c = 3;
      while (!bd.done && c < 40) begin
         tick;
         c++;
      end
      chk("ign_latency", c, 32'd8);
      chk("ign_bcd", 32'(bd.bcdOut), 32'h099);
      seen = 0;
      repeat (12) begin
         tick;
         seen += int'(bd.done);
      end
      chk("ign_single_done", seen, 32'd0);
      bd.start = 1'b1;
      bd.binIn = 8'd200;
      tick;
      bd.start = 1'b0;
      repeat (3) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_busy", 32'(bd.busy), 32'd0);
      chk("abort_done", 32'(bd.done), 32'd0);
      chk("abort_bcd", 32'(bd.bcdOut), 32'd0);
      seen = 0;
      repeat (12) begin
         tick;
         seen += int'(bd.done);
      end
      chk("abort_no_done", seen, 32'd0);
      last_bcd = '0;
      conv_d(8'd42);
      bd.start = 1'b1;
      bd.binIn = 8'd128;
      tick;
      bd.start = 1'b0;
      c = 0;
      repeat (3) begin
         tick;
         c++;
      end
      bd.ena = 1'b0;
      repeat (5) begin
         tick;
         c++;
      end
      chk("stall_busy", 32'(bd.busy), 32'd1);
      chk("stall_done", 32'(bd.done), 32'd0);
      bd.ena = 1'b1;
      while (!bd.done && c < 40) begin
         tick;
         c++;
      end
      chk("stall_latency", c, 32'd13);
      bd.ena = 1'b0;
      tick;
      chk("stall_done_hold1", 32'(bd.done), 32'd1);
      tick;
      chk("stall_done_hold2", 32'(bd.done), 32'd1);
      bd.ena = 1'b1;
      tick;
      chk("stall_done_drop", 32'(bd.done), 32'd0);
      chk("stall_bcd", 32'(bd.bcdOut), 32'h128);
      run_all(16'hFFFF);
      repeat (12) run_all(16'($urandom));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
